// File: rtl/stage_ex.sv
// Execute stage: operand forwarding, ALU, iterative multiplier, branch
// resolution and the EX/MA pipeline register.
//
// Ports:
//   Clk, Rst               clock, synchronous active-high reset
//   i_ex_*                 ID/EX slot (valid, IC/PC, prediction, operands,
//                          immediate, RS2/RDS, EX/MA/WB control fields)
//   i_ex_fwd_ma/_wb        forwarded EX/MA result and WB write data
//   i_OP1_ExS/i_OP2_ExS    operand source selects
//   i_ex_stall/i_ex_flush  hold / bubble the EX/MA register
//   o_ex_*                 EX/MA register contents
//   o_ex_busy              multiplier occupied, upstream must hold ID/EX
//   o_JmpAddr, o_JmpInstrAddr, o_FlushPipeandPC, o_WriteEnable, o_CB
//                          same-cycle branch resolution and predictor update
module stage_ex #(
    parameter int DW         = 32,
    parameter int RW         = 5,
    parameter int MUL_CYCLES = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          i_ex_valid,
    input  logic [DW-1:0] i_ex_IC,
    input  logic [DW-1:0] i_ex_PC,
    input  logic          i_ex_PPCCB,
    input  logic [DW-1:0] i_ex_OP1,
    input  logic [DW-1:0] i_ex_OP2,
    input  logic [DW-1:0] i_ex_IM,
    input  logic [RW-1:0] i_ex_RS2,
    input  logic [RW-1:0] i_ex_RDS,
    input  logic [7:0]    i_ex_EX,
    input  logic [1:0]    i_ex_MA,
    input  logic [2:0]    i_ex_WB,
    input  logic [DW-1:0] i_ex_fwd_ma,
    input  logic [DW-1:0] i_ex_fwd_wb,
    input  logic [1:0]    i_OP1_ExS,
    input  logic [1:0]    i_OP2_ExS,
    input  logic          i_ex_stall,
    input  logic          i_ex_flush,
    output logic          o_ex_valid,
    output logic [DW-1:0] o_ex_PC,
    output logic [DW-1:0] o_ex_ALU_rslt,
    output logic [DW-1:0] o_ex_Rs2_val,
    output logic [RW-1:0] o_ex_Rs2_addr,
    output logic [RW-1:0] o_ex_Rdst,
    output logic [1:0]    o_ex_MA,
    output logic [2:0]    o_ex_WB,
    output logic          o_ex_busy,
    output logic [DW-1:0] o_JmpAddr,
    output logic [DW-1:0] o_JmpInstrAddr,
    output logic          o_FlushPipeandPC,
    output logic          o_WriteEnable,
    output logic          o_CB
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [DW-1:0] acc, mcand, mplier;

    logic [3:0]    aluop;
    logic          alusrc, link;
    logic [1:0]    br;
    logic [DW-1:0] a, bfwd, b, alu, result, tgt;
    logic [4:0]    shamt;
    logic          start, busy, last, br_ok, cond, taken, load_ok;

    assign aluop  = i_ex_EX[3:0];
    assign alusrc = i_ex_EX[4];
    assign br     = i_ex_EX[6:5];
    assign link   = i_ex_EX[7];

    always_comb begin
        case (i_OP1_ExS)
            2'b01:   a = i_ex_fwd_ma;
            2'b10:   a = i_ex_fwd_wb;
            default: a = i_ex_OP1;
        endcase
        case (i_OP2_ExS)
            2'b01:   bfwd = i_ex_fwd_ma;
            2'b10:   bfwd = i_ex_fwd_wb;
            default: bfwd = i_ex_OP2;
        endcase
    end

    assign b     = alusrc ? i_ex_IM : bfwd;
    assign shamt = b[4:0];

    // MUL (11) yields 0 here; its product comes from the iterative unit.
    always_comb begin
        alu = '0;
        case (aluop)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a & b;
            4'd3:    alu = a | b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = a << shamt;
            4'd6:    alu = a >> shamt;
            4'd7:    alu = $unsigned($signed(a) >>> shamt);
            4'd8:    alu = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            4'd9:    alu = {{(DW-1){1'b0}}, a < b};
            4'd10:   alu = b;
            default: alu = '0;
        endcase
    end

    assign result = link ? i_ex_PC : alu;

    assign start = (state == IDLE) && i_ex_valid && !i_ex_stall
                   && (aluop == 4'd11);
    assign last  = (cnt == CW'(MUL_CYCLES - 1));

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    busy    = 1'b1;
                    state_n = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (i_ex_stall)
            state_n = state;
        if (i_ex_flush)
            state_n = IDLE;
    end

    assign o_ex_busy = busy;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            state <= state_n;
            if (!i_ex_flush && !i_ex_stall) begin
                if (start) begin
                    mcand  <= a;
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                end else if (state == MUL) begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
            end
        end
    end

    assign tgt = i_ex_IC + i_ex_IM;

    always_comb begin
        br_ok = i_ex_valid && !busy && !i_ex_stall;
        case (br)
            2'b01:   cond = (a == bfwd);
            2'b10:   cond = (a != bfwd);
            2'b11:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
        taken            = br_ok && cond;
        o_CB             = taken;
        o_WriteEnable    = br_ok && (br != 2'b00);
        o_JmpAddr        = br_ok ? (taken ? tgt : i_ex_PC) : '0;
        o_JmpInstrAddr   = br_ok ? i_ex_IC : '0;
        o_FlushPipeandPC = br_ok && (taken != i_ex_PPCCB);
    end

    // While the multiplier is busy the register takes bubbles; DONE
    // writes the accumulated product with the held instruction's fields.
    assign load_ok = i_ex_valid && !busy;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            o_ex_valid    <= 1'b0;
            o_ex_PC       <= '0;
            o_ex_ALU_rslt <= '0;
            o_ex_Rs2_val  <= '0;
            o_ex_Rs2_addr <= '0;
            o_ex_Rdst     <= '0;
            o_ex_MA       <= '0;
            o_ex_WB       <= '0;
        end else if (i_ex_flush) begin
            o_ex_valid <= 1'b0;
            o_ex_MA    <= '0;
            o_ex_WB    <= '0;
        end else if (!i_ex_stall) begin
            o_ex_valid    <= load_ok;
            o_ex_PC       <= i_ex_PC;
            o_ex_ALU_rslt <= (state == DONE) ? acc : result;
            o_ex_Rs2_val  <= bfwd;
            o_ex_Rs2_addr <= i_ex_RS2;
            o_ex_Rdst     <= i_ex_RDS;
            o_ex_MA       <= load_ok ? i_ex_MA : 2'b00;
            o_ex_WB       <= load_ok ? i_ex_WB : 3'b000;
        end
    end

endmodule
